// File: rtl/aes_round_sequencer.sv
// AES core top-level sequencer: key-expansion handshake, round stepping, command filtering.
// Optional decrypt counting (round index runs downward) is enabled by defining AES_SEQ_DEC_EN.
module aes_round_sequencer #(
  parameter int KEY_TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keylen,
  input  logic       key_init,
  input  logic       block_start,
  input  logic       key_ready_i,
`ifdef AES_SEQ_DEC_EN
  input  logic       decrypt,
`endif
  output logic       key_init_o,
  output logic [3:0] round,
  output logic [1:0] round_type,
  output logic       dp_update,
  output logic       busy,
  output logic       key_valid,
  output logic       result_valid,
  output logic       key_err,
  output logic       cmd_reject
);

  typedef enum logic [2:0] {IDLE, KEY_REQ, KEY_WAIT, ROUND, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] round_nxt, num_rounds;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic       keylen_reg, keylen_nxt;
  logic       low_seen, low_seen_nxt;
  logic       dec_reg, dec_nxt, dec_in;
  logic       key_valid_nxt, result_valid_nxt, key_err_nxt, reject_nxt;
  logic       first_step, last_step;

`ifdef AES_SEQ_DEC_EN
  assign dec_in = decrypt;
`else
  assign dec_in = 1'b0;
`endif

  assign num_rounds = keylen_reg ? 4'd14 : 4'd10;
  assign cnt_inc    = cnt + 8'd1;

  // Direction-aware round markers: decrypt walks num_rounds down to 0.
  assign first_step = dec_reg ? (round == num_rounds) : (round == 4'd0);
  assign last_step  = dec_reg ? (round == 4'd0) : (round == num_rounds);

  always_comb begin
    round_type = 2'd0;
    if (state == ROUND) begin
      if (first_step)     round_type = 2'd0;
      else if (last_step) round_type = 2'd2;
      else                round_type = 2'd1;
    end
  end

  assign dp_update  = (state == ROUND);
  assign key_init_o = (state == KEY_REQ);

  always_comb begin
    state_nxt        = state;
    round_nxt        = round;
    cnt_nxt          = cnt;
    keylen_nxt       = keylen_reg;
    low_seen_nxt     = low_seen;
    dec_nxt          = dec_reg;
    key_valid_nxt    = key_valid;
    result_valid_nxt = result_valid;
    key_err_nxt      = key_err;
    reject_nxt       = (state != IDLE) && (key_init || block_start);
    case (state)
      IDLE: begin
        if (key_init) begin
          keylen_nxt       = keylen;
          key_valid_nxt    = 1'b0;
          result_valid_nxt = 1'b0;
          key_err_nxt      = 1'b0;
          reject_nxt       = block_start;
          state_nxt        = KEY_REQ;
        end else if (block_start) begin
          if (key_valid) begin
            result_valid_nxt = 1'b0;
            dec_nxt          = dec_in;
            round_nxt        = dec_in ? num_rounds : 4'd0;
            state_nxt        = ROUND;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      KEY_REQ: begin
        low_seen_nxt = 1'b0;
        cnt_nxt      = 8'd0;
        state_nxt    = KEY_WAIT;
      end
      KEY_WAIT: begin
        cnt_nxt = cnt_inc;
        if (!key_ready_i) low_seen_nxt = 1'b1;
        // Only a ready that rose after a low phase belongs to this expansion.
        if (key_ready_i && low_seen) begin
          key_valid_nxt = 1'b1;
          state_nxt     = IDLE;
        end else if (cnt_inc == 8'(KEY_TIMEOUT)) begin
          key_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ROUND: begin
        if (last_step) begin
          round_nxt = 4'd0;
          state_nxt = DONE;
        end else begin
          round_nxt = dec_reg ? round - 4'd1 : round + 4'd1;
        end
      end
      DONE: begin
        result_valid_nxt = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      round        <= 4'd0;
      cnt          <= 8'd0;
      keylen_reg   <= 1'b0;
      low_seen     <= 1'b0;
      dec_reg      <= 1'b0;
      busy         <= 1'b0;
      key_valid    <= 1'b0;
      result_valid <= 1'b0;
      key_err      <= 1'b0;
      cmd_reject   <= 1'b0;
    end else begin
      state        <= state_nxt;
      round        <= round_nxt;
      cnt          <= cnt_nxt;
      keylen_reg   <= keylen_nxt;
      low_seen     <= low_seen_nxt;
      dec_reg      <= dec_nxt;
      busy         <= (state_nxt != IDLE);
      key_valid    <= key_valid_nxt;
      result_valid <= result_valid_nxt;
      key_err      <= key_err_nxt;
      cmd_reject   <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a round/round_type scoreboard.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       reset, keylen, key_init, block_start, key_ready_i;
`ifdef AES_SEQ_DEC_EN
  logic       decrypt;
`endif
  logic       key_init_o, dp_update, busy, key_valid, result_valid, key_err, cmd_reject;
  logic [3:0] round;
  logic [1:0] round_type;

  int checks = 0;
  int errors = 0;
  int rej_cnt = 0;
  int kio_cnt = 0;
  logic [3:0] exp_round[$];
  logic [1:0] exp_type[$];

  aes_round_sequencer #(.KEY_TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .keylen(keylen), .key_init(key_init),
    .block_start(block_start), .key_ready_i(key_ready_i),
`ifdef AES_SEQ_DEC_EN
    .decrypt(decrypt),
`endif
    .key_init_o(key_init_o), .round(round), .round_type(round_type),
    .dp_update(dp_update), .busy(busy), .key_valid(key_valid),
    .result_valid(result_valid), .key_err(key_err), .cmd_reject(cmd_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every datapath step is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (cmd_reject) rej_cnt++;
    if (key_init_o) kio_cnt++;
    if (dp_update) begin
      if (exp_round.size() == 0) begin
        chk("unexpected_dp_update", 32'(round), 32'hFFFF);
      end else begin
        chk("sb_round", 32'(round), 32'(exp_round.pop_front()));
        chk("sb_round_type", 32'(round_type), 32'(exp_type.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drop_ready: ready falls after key_init_o; raise_ready: rises 12 cycles later.
  task automatic do_key(input logic kl, input logic with_block, input logic raise_ready,
                        input int exp_cycles, input logic exp_valid, input logic exp_err);
    int c, rej0, kio0;
    rej0 = rej_cnt;
    kio0 = kio_cnt;
    key_init = 1'b1; keylen = kl; block_start = with_block;
    tick();
    key_init = 1'b0; block_start = 1'b0; keylen = ~kl;
    c = 0;
    chk("key_init_o_high", 32'(key_init_o), 32'd1);
    tick(); c = 1;
    chk("key_init_o_single", 32'(key_init_o), 32'd0);
    key_ready_i = 1'b0;
    while (!key_valid && !key_err && c < 80) begin
      if (raise_ready && c == 13) key_ready_i = 1'b1;
      tick(); c++;
    end
    chk("key_done_cycles", 32'(c), 32'(exp_cycles));
    chk("key_valid", 32'(key_valid), 32'(exp_valid));
    chk("key_err", 32'(key_err), 32'(exp_err));
    chk("key_busy_after", 32'(busy), 32'd0);
    chk("key_init_o_pulses", 32'(kio_cnt - kio0), 32'd1);
    tick();
    chk("key_rejects", 32'(rej_cnt - rej0), 32'(with_block));
  endtask

  task automatic run_block(input int n, input logic dec, input int reject_at);
    int c, rej0;
    logic rejected;
    rej0 = rej_cnt;
    rejected = 1'b0;
    for (int s = 0; s <= n; s++) begin
      exp_round.push_back(4'(dec ? n - s : s));
      exp_type.push_back(s == 0 ? 2'd0 : (s == n ? 2'd2 : 2'd1));
    end
    block_start = 1'b1;
`ifdef AES_SEQ_DEC_EN
    decrypt = dec;
`endif
    tick();
    block_start = 1'b0;
    c = 0;
    chk("blk_result_cleared", 32'(result_valid), 32'd0);
    chk("blk_busy", 32'(busy), 32'd1);
    while (!result_valid && c < 40) begin
      if (block_start) block_start = 1'b0;
      if (!rejected && reject_at >= 0 && round == 4'(reject_at)) begin
        block_start = 1'b1;
        rejected = 1'b1;
      end
      tick(); c++;
    end
    block_start = 1'b0;
    chk("blk_result_latency", 32'(c), 32'(n + 2));
    chk("blk_round_zero", 32'(round), 32'd0);
    chk("blk_busy_done", 32'(busy), 32'd0);
    chk("blk_sb_empty", 32'(exp_round.size()), 32'd0);
    tick();
    chk("blk_rejects", 32'(rej_cnt - rej0), 32'(reject_at >= 0));
    chk("blk_result_held", 32'(result_valid), 32'd1);
  endtask

  initial begin
    int c, rej0;
    reset = 1'b1; keylen = 1'b0; key_init = 1'b0; block_start = 1'b0; key_ready_i = 1'b1;
`ifdef AES_SEQ_DEC_EN
    decrypt = 1'b0;
`endif
    #12;
    chk("reset_outputs", 32'({key_init_o, round, round_type, dp_update, busy, key_valid,
                              result_valid, key_err, cmd_reject}), 32'd0);
    @(negedge clk); reset = 1'b0;
    tick();

    do_key(1'b0, 1'b0, 1'b1, 14, 1'b1, 1'b0);
    run_block(10, 1'b0, -1);
    do_key(1'b1, 1'b0, 1'b1, 14, 1'b1, 1'b0);
    run_block(14, 1'b0, -1);

    // Ready never returns: abort after KEY_TIMEOUT cycles in KEY_WAIT.
    do_key(1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b1);
    rej0 = rej_cnt;
    block_start = 1'b1; tick(); block_start = 1'b0; tick();
    chk("reject_no_key", 32'(rej_cnt - rej0), 32'd1);
    chk("reject_no_key_busy", 32'(busy), 32'd0);

    do_key(1'b0, 1'b0, 1'b1, 14, 1'b1, 1'b0);
    run_block(10, 1'b0, 5);
    do_key(1'b0, 1'b1, 1'b1, 14, 1'b1, 1'b0);

`ifdef AES_SEQ_DEC_EN
    run_block(10, 1'b1, -1);
`endif

    // Reset mid-block at round 7.
    for (int s = 0; s <= 10; s++) begin
      exp_round.push_back(4'(s));
      exp_type.push_back(s == 0 ? 2'd0 : (s == 10 ? 2'd2 : 2'd1));
    end
    block_start = 1'b1; tick(); block_start = 1'b0;
    c = 0;
    while (round != 4'd7 && c < 20) begin tick(); c++; end
    chk("reached_round7", 32'(round), 32'd7);
    #6 reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({key_init_o, round, round_type, dp_update, busy, key_valid,
                                    result_valid, key_err, cmd_reject}), 32'd0);
    exp_round.delete();
    exp_type.delete();
    @(negedge clk); reset = 1'b0;
    tick();
    chk("post_reset_key_valid", 32'(key_valid), 32'd0);
    rej0 = rej_cnt;
    block_start = 1'b1; tick(); block_start = 1'b0; tick();
    chk("post_reset_reject", 32'(rej_cnt - rej0), 32'd1);
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Top-level sequencer for the AES core.
- Issues key-expansion init to the key memory block and waits for that block to report ready.
- For each data block, steps a round index that addresses the round-key memory and drives the round datapath. Tags each step as initial, main or final round.
- Rejects commands that are illegal in the current state and flags key-expansion timeouts.

Parameters:
- KEY_TIMEOUT, 31: max cycles in KEY_WAIT before abort; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled only with key_init
- key_init  in  1  command pulse: expand new key
- block_start  in  1  command pulse: process one block
- key_ready_i  in  1  ready level from key expander
- key_init_o  out  1  one-cycle init pulse to key expander
- round  out  4  round index to key memory read port and datapath
- round_type  out  2  0 = INIT (AddRoundKey only), 1 = MAIN, 2 = FINAL (no MixColumns), 3 = unused
- dp_update  out  1  datapath register enable for the current round
- busy  out  1  high in any state other than IDLE
- key_valid  out  1  expanded key usable
- result_valid  out  1  level; block result available
- key_err  out  1  sticky timeout flag
- cmd_reject  out  1  one-cycle pulse when a command is dropped

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0, round = 0.
  - keylen_reg = 0, timeout counter = 0, low_seen = 0.
- num_rounds = keylen_reg ? 14 : 10.
- States: IDLE, KEY_REQ, KEY_WAIT, ROUND, DONE.
- IDLE:
  - key_init = 1: capture keylen into keylen_reg; clear key_valid, result_valid and key_err; go to KEY_REQ.
  - Else block_start = 1 with key_valid = 1: clear result_valid; round = 0; go to ROUND.
  - block_start with key_valid = 0: pulse cmd_reject; stay in IDLE.
  - key_init and block_start in the same cycle: key_init wins; block_start is rejected with a cmd_reject pulse.
- KEY_REQ:
  - key_init_o = 1 for exactly this cycle.
  - Clear low_seen and the timeout counter; go to KEY_WAIT.
- KEY_WAIT:
  - key_ready_i = 0: set low_seen.
  - key_ready_i = 1 with low_seen = 1: set key_valid; go to IDLE. A stale ready still high from the previous key is therefore never accepted.
  - Counter increments every cycle. When it reaches KEY_TIMEOUT without completion: set key_err; key_valid stays 0; go to IDLE.
- ROUND:
  - dp_update = 1 every cycle.
  - round_type: INIT when round = 0, FINAL when round = num_rounds, else MAIN.
  - round < num_rounds: round increments by 1.
  - round = num_rounds: go to DONE; round returns to 0.
- DONE:
  - Set result_valid (held until the next accepted block_start or key_init); go to IDLE.
- Latency:
  - block_start sampled at edge T: round 0 is presented in cycle T+1, round N in cycle T+1+N.
  - result_valid rises at edge T+2+N, i.e. 12 cycles after T for AES-128 and 16 for AES-256.
- Commands in any non-IDLE state:
  - Dropped, one cmd_reject pulse per offending cycle.
  - No effect on state, keylen_reg or flags.
- keylen changes outside a key_init cycle are ignored.
- busy is a registered decode of the state.
- round_type and dp_update are combinational from the state and round registers.
- Reset asserted mid-operation: returns immediately to reset values; key_valid is lost and a new key_init is required.

Optional Feature:
- AES_SEQ_DEC_EN defined:
  - Adds input decrypt (1 bit), sampled with block_start.
  - Decrypt blocks start ROUND at round = num_rounds and decrement to 0.
  - round_type is INIT at the first step and FINAL at round = 0.
  - Latency is the same as encrypt.
- AES_SEQ_DEC_EN undefined: port absent; encrypt-only counting.

Test Plan:
- Reset, then key_init with keylen = 0; model drops ready the cycle after key_init_o, then raises it 12 cycles later -> single-cycle key_init_o, key_valid = 1 after the rise, busy low afterwards, key_err = 0.
- With an AES-128 key valid, block_start at edge T -> round steps 0..10 in cycles T+1..T+11; round_type sequence 0, then 1 ×9, then 2; result_valid = 1 at edge T+12.
- key_init with keylen = 1, then block_start -> round steps 0..14; result_valid at edge T+16; round returns to 0.
- key_ready_i held low after key_init_o -> key_err = 1 at KEY_TIMEOUT (31) cycles; key_valid = 0; a following block_start produces a cmd_reject pulse.
- block_start at round 5 of an active block, then key_init and block_start asserted together in IDLE -> one cmd_reject pulse each time; the active block completes unchanged; key expansion starts.
- Reset asserted at round 7 -> all outputs 0 asynchronously; key_valid = 0 after release. With AES_SEQ_DEC_EN and decrypt = 1, keylen = 0 -> round sequence 10..0 with INIT first and FINAL last.
